// File: rtl/fpga_cmd_rx.sv
// HF FPGA configuration front end: oversampled SPI command receiver, config registers and glitch-free major-mode switching.
// Optional macro FPGA_CMD_READBACK_EN enables the miso readback word and the error counter.
module fpga_cmd_rx #(
    parameter int                CMD_W       = 4,
    parameter int                DATA_W      = 12,
    parameter int                NUM_REGS    = 4,
    parameter int                SYNC_STAGES = 2,
    parameter int                MODE_W      = 3,
    parameter int                MODE_LSB    = 5,
    parameter logic [MODE_W-1:0] MODE_OFF    = 3'b111,
    parameter int                HOLDOFF     = 16
) (
    input  logic                         ck_1356meg,
    input  logic                         reset,
    input  logic                         spck,
    input  logic                         mosi,
    input  logic                         ncs,
    output logic                         miso,
    output logic [NUM_REGS*DATA_W-1:0]   conf_regs,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic [MODE_W-1:0]            major_mode,
    output logic                         mode_switching,
    output logic                         frame_err
);

    localparam int FRAME_W = CMD_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam int HCNT_W  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [CMD_W-1:0]  NUM_REGS_C = CMD_W'(NUM_REGS);
    localparam logic [CNT_W-1:0]  FRAME_LEN  = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(FRAME_W + 1);
    localparam logic [HCNT_W-1:0] HOLD_LOAD  = HCNT_W'(HOLDOFF - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_COMMIT} rx_state_t;
    typedef enum logic {MD_STABLE, MD_QUIESCE} md_state_t;

    rx_state_t rx_state, rx_next;
    md_state_t md_state, md_next;

    logic [SYNC_STAGES-1:0] spck_sync, mosi_sync, ncs_sync;
    logic spck_d, ncs_d, spck_rise, ncs_rise, ncs_fall, mosi_q;

    logic [FRAME_W-1:0] shreg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  regs [NUM_REGS];

    logic [CMD_W-1:0]    cmd;
    logic [DATA_W-1:0]   payload;
    logic                frame_ok, wr_valid, err;
    logic [NUM_REGS-1:0] wr_sel;

    logic [MODE_W-1:0] target, major_nx;
    logic              sw_nx;
    logic [HCNT_W-1:0] hcnt, hcnt_nx;

    // Edge pulses are registered, so they line up with the registered mosi sample.
    always_ff @(posedge ck_1356meg or posedge reset) begin
        if (reset) begin
            spck_sync <= '0;
            mosi_sync <= '0;
            ncs_sync  <= '1;
            spck_d    <= 1'b0;
            ncs_d     <= 1'b1;
            spck_rise <= 1'b0;
            ncs_rise  <= 1'b0;
            ncs_fall  <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            spck_sync <= {spck_sync[SYNC_STAGES-2:0], spck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            spck_d    <= spck_sync[SYNC_STAGES-1];
            ncs_d     <= ncs_sync[SYNC_STAGES-1];
            spck_rise <= spck_sync[SYNC_STAGES-1] & ~spck_d;
            ncs_rise  <= ncs_sync[SYNC_STAGES-1] & ~ncs_d;
            ncs_fall  <= ~ncs_sync[SYNC_STAGES-1] & ncs_d;
            mosi_q    <= mosi_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge ck_1356meg or posedge reset) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            md_state <= MD_STABLE;
        end else begin
            rx_state <= rx_next;
            md_state <= md_next;
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:   if (ncs_fall) rx_next = RX_SHIFT;
            RX_SHIFT:  if (ncs_rise) rx_next = RX_COMMIT;
            RX_COMMIT: rx_next = RX_IDLE;
            default:   rx_next = RX_IDLE;
        endcase
    end

    assign cmd     = shreg[FRAME_W-1 -: CMD_W];
    assign payload = shreg[DATA_W-1:0];

    // A correctly sized cmd 0 is a silent NOP; any wrong length is an error regardless of cmd.
    always_comb begin
        frame_ok = (bit_cnt == FRAME_LEN);
        wr_valid = 1'b0;
        err      = 1'b0;
        wr_sel   = '0;
        if (rx_state == RX_COMMIT) begin
            if (frame_ok && cmd != '0 && cmd <= NUM_REGS_C)
                wr_valid = 1'b1;
            else if (!(frame_ok && cmd == '0))
                err = 1'b1;
        end
        for (int unsigned i = 0; i < NUM_REGS; i++)
            wr_sel[i] = wr_valid && (cmd == CMD_W'(i + 1));
    end

    always_ff @(posedge ck_1356meg or posedge reset) begin
        if (reset) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            wr_strobe <= '0;
            frame_err <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            regs[0][MODE_LSB +: MODE_W] <= MODE_OFF;
        end else begin
            wr_strobe <= wr_sel;
            frame_err <= err;
            if (rx_state == RX_IDLE && ncs_fall) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end else if (rx_state == RX_SHIFT && spck_rise) begin
                shreg <= {shreg[FRAME_W-2:0], mosi_q};
                if (bit_cnt != CNT_SAT)
                    bit_cnt <= bit_cnt + 1'b1;
            end
            for (int unsigned i = 0; i < NUM_REGS; i++)
                if (wr_sel[i])
                    regs[i] <= payload;
        end
    end

    always_comb begin
        conf_regs = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++)
            conf_regs[i*DATA_W +: DATA_W] = regs[i];
    end

    assign target = regs[0][MODE_LSB +: MODE_W];

    // Any rewrite of reg[0] during quiesce restarts the off interval with the newest target.
    always_comb begin
        md_next  = md_state;
        major_nx = major_mode;
        sw_nx    = mode_switching;
        hcnt_nx  = hcnt;
        case (md_state)
            MD_STABLE: begin
                if (target != major_mode) begin
                    major_nx = MODE_OFF;
                    if (target != MODE_OFF) begin
                        sw_nx   = 1'b1;
                        hcnt_nx = HOLD_LOAD;
                        md_next = MD_QUIESCE;
                    end
                end
            end
            MD_QUIESCE: begin
                if (wr_strobe[0]) begin
                    hcnt_nx = HOLD_LOAD;
                end else if (hcnt == '0) begin
                    major_nx = target;
                    sw_nx    = 1'b0;
                    md_next  = MD_STABLE;
                end else begin
                    hcnt_nx = hcnt - 1'b1;
                end
            end
            default: md_next = MD_STABLE;
        endcase
    end

    always_ff @(posedge ck_1356meg or posedge reset) begin
        if (reset) begin
            major_mode     <= MODE_OFF;
            mode_switching <= 1'b0;
            hcnt           <= '0;
        end else begin
            major_mode     <= major_nx;
            mode_switching <= sw_nx;
            hcnt           <= hcnt_nx;
        end
    end

`ifdef FPGA_CMD_READBACK_EN
    logic [DATA_W-1:0]  err_cnt, err_cnt_nx;
    logic [FRAME_W-1:0] rb_word, rb_sh;
    logic               spck_fall, miso_q;

    always_comb begin
        err_cnt_nx = err_cnt;
        if (err && err_cnt != '1)
            err_cnt_nx = err_cnt + 1'b1;
    end

    // First bit is presented on the ncs fall so it is valid before the first spck rise.
    always_ff @(posedge ck_1356meg or posedge reset) begin
        if (reset) begin
            err_cnt   <= '0;
            rb_word   <= '0;
            rb_sh     <= '0;
            spck_fall <= 1'b0;
            miso_q    <= 1'b0;
        end else begin
            err_cnt   <= err_cnt_nx;
            spck_fall <= ~spck_sync[SYNC_STAGES-1] & spck_d;
            if (rx_state == RX_COMMIT)
                rb_word <= wr_valid ? {cmd, payload} : {{CMD_W{1'b1}}, err_cnt_nx};
            if (ncs_sync[SYNC_STAGES-1]) begin
                miso_q <= 1'b0;
            end else if (rx_state == RX_IDLE && ncs_fall) begin
                miso_q <= rb_word[FRAME_W-1];
                rb_sh  <= {rb_word[FRAME_W-2:0], 1'b0};
            end else if (rx_state == RX_SHIFT && spck_fall) begin
                miso_q <= rb_sh[FRAME_W-1];
                rb_sh  <= {rb_sh[FRAME_W-2:0], 1'b0};
            end
        end
    end

    assign miso = miso_q;
`else
    assign miso = 1'b0;
`endif

endmodule

// File: doc/fpga_cmd_rx.md
Name: fpga_cmd_rx

Overview:
- Next-generation configuration front end for the HF FPGA image.
- Samples the ARM SPI link (spck/mosi/ncs) synchronously in the ck_1356meg domain instead of clocking on the SPI edges.
- Decodes 16-bit command frames into NUM_REGS parametrised configuration registers.
- Gates major-mode changes through an all-off quiesce interval, so the output muxes never switch directly between two active modes and the carrier does not glitch.

Parameters:
- CMD_W, 4: command field width (frame MSBs).
- DATA_W, 12: payload width; frame length FRAME_W = CMD_W+DATA_W.
- NUM_REGS, 4: number of config registers; command c (1..NUM_REGS) writes reg[c-1].
- SYNC_STAGES, 2: synchroniser depth on spck/mosi/ncs (minimum 2).
- MODE_W, 3: major-mode field width.
- MODE_LSB, 5: bit position of the mode field within reg[0].
- MODE_OFF, 3'b111: "everything off" mode code; also the reset mode.
- HOLDOFF, 16: quiesce length in clocks (minimum 1).

Ports:
- ck_1356meg  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high.
- spck  in  1  SPI clock, asynchronous; must be ≤ ck_1356meg/4.
- mosi  in  1  SPI data, asynchronous; sampled on a detected spck rise.
- ncs  in  1  SPI chip select, asynchronous, active-low.
- miso  out  1  readback data (see Optional Feature).
- conf_regs  out  NUM_REGS*DATA_W  flattened registers; reg[i] occupies bits [i*DATA_W +: DATA_W].
- wr_strobe  out  NUM_REGS  one-cycle pulse on bit i when reg[i] is written.
- major_mode  out  MODE_W  active mode driving the downstream mux8 selects.
- mode_switching  out  1  high during quiesce.
- frame_err  out  1  one-cycle pulse on a malformed or unknown frame.

Behaviour:
- Reset values:
  - reg[0] = MODE_OFF<<MODE_LSB; other regs 0.
  - major_mode = MODE_OFF.
  - wr_strobe, frame_err, mode_switching, miso = 0.
  - Shift register and bit count = 0; both FSMs return to IDLE/STABLE.
- Synchronisation: each SPI input passes through SYNC_STAGES flops. Edge detectors compare the last two synchronised samples.
- Receive FSM:
  - IDLE: sync ncs high. On sync ncs falling → SHIFT, clear shift register and count.
  - SHIFT: on each sync spck rise, shift in the sync mosi (MSB first) and increment the count. The count saturates at FRAME_W+1. A sync ncs rise → COMMIT.
  - COMMIT (one cycle), then → IDLE:
    - If count == FRAME_W and 1 ≤ cmd ≤ NUM_REGS: write reg[cmd-1] and pulse wr_strobe[cmd-1].
    - If cmd == 0: NOP, no error.
    - Otherwise (wrong length or cmd > NUM_REGS): pulse frame_err and write nothing.
- Commit latency: the register update and wr_strobe occur exactly SYNC_STAGES+2 clocks after the first clock edge that samples ncs high.
- Mode FSM:
  - Target = reg[0][MODE_LSB +: MODE_W].
  - STABLE: if target ≠ major_mode:
    - If target == MODE_OFF: major_mode ← MODE_OFF on the next clock, remain STABLE.
    - Else: major_mode ← MODE_OFF, mode_switching ← 1, counter ← HOLDOFF-1, → QUIESCE.
  - QUIESCE: counter decrements each clock. If reg[0] is rewritten, the counter reloads HOLDOFF-1 and the latest target is used. At count 0: major_mode ← target (MODE_OFF if target is now MODE_OFF), mode_switching ← 0, → STABLE.
  - Writing an identical mode, or any write to reg[1..], never disturbs major_mode.
  - Result: between any two distinct non-off modes, major_mode holds MODE_OFF for exactly HOLDOFF clocks.
- Simultaneous events: a sync ncs rise and a spck rise in the same cycle → the bit is shifted first, then COMMIT.
- Reset mid-frame: the partial frame is discarded and nothing is written.
- ncs glitch (fall then rise with no spck edges): count = 0 → frame_err.

Optional Feature:
- Macro: FPGA_CMD_READBACK_EN.
- Defined:
  - At each COMMIT, a 16-bit readback word is loaded: {cmd, reg[cmd-1]} after a valid write, otherwise {CMD_W'hF, DATA_W'(error count, saturating)}.
  - During the next frame, miso presents the word MSB-first, updating on each sync spck fall. miso is 0 while ncs is high.
- Undefined: miso tied to 0; no readback word or error counter is synthesised.

Test Plan:
- Reset → major_mode=3'b111, conf_regs reg[0]=12'h0E0, others 0, mode_switching=0.
- Frame 16'h1020 (mode 1) → wr_strobe[0] pulses; major_mode stays 7 for 16 clocks with mode_switching=1, then becomes 1.
- Mode 1 active, frame 16'h1040 → major_mode=7 for exactly 16 clocks, then 2; it never goes directly 1→2. Frame 16'h1040 again → no change.
- Frame 16'h3ABC → reg[2]=12'hABC, wr_strobe[2] pulses, major_mode unchanged; frame 16'h5000 → frame_err pulses, no write.
- 15-bit frame, and 17-bit frame → frame_err each time, all regs unchanged; assert reset at bit 8 → no write, FSM back in IDLE.
- With FPGA_CMD_READBACK_EN defined: write 16'h2123, then send 16'h0000 → miso returns 16'h2123 MSB-first.
